// File: rtl/npc_fetch_ctrl.sv
// Next-PC generator and instruction-fetch controller: fetches at PC over req/ack,
// hands the instruction to decode over valid/ready, and steers the pc register via NPC.
module npc_fetch_ctrl #(
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [ADDR_W-1:0] o_npc,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [DATA_W-1:0] i_imem_data,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_align_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_align_err;
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_pc;

  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_npc;
  logic              w_take;
  logic              w_ld_addr;
  logic              w_pend_set;
  logic              w_pend_clr;

  assign w_tgt = {i_redirect_pc[ADDR_W-1:2], 2'b00};

  always_comb begin
    w_next     = r_state;
    w_npc      = i_pc;
    w_take     = 1'b0;
    w_pend_set = 1'b0;
    w_pend_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_redirect) w_npc = w_tgt;
        w_next = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          // A redirect seen now or earlier in this fetch makes the returned data stale.
          if (i_redirect) begin
            w_npc      = w_tgt;
            w_pend_clr = 1'b1;
          end else if (r_pend) begin
            w_npc      = r_pend_pc;
            w_pend_clr = 1'b1;
          end else begin
            w_npc  = i_pc + ADDR_W'(4);
            w_take = 1'b1;
            w_next = S_HOLD;
          end
        end else if (i_redirect) begin
          w_pend_set = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_redirect) begin
          w_npc  = w_tgt;
          w_next = S_FETCH;
        end else if (i_instr_ready) begin
          w_next = S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // New request address is the PC the pc register will hold next cycle; an
  // unacknowledged request keeps its address.
  assign w_ld_addr = (w_next == S_FETCH) && !((r_state == S_FETCH) && !i_imem_ack);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_instr     <= '0;
      r_instr_pc  <= '0;
      r_align_err <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_pc   <= '0;
    end else begin
      r_state     <= w_next;
      r_align_err <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
      if (w_ld_addr) r_addr <= w_npc;
      if (w_take) begin
        r_instr    <= i_imem_data;
        r_instr_pc <= r_addr;
      end
      if (w_pend_set) begin
        r_pend    <= 1'b1;
        r_pend_pc <= w_tgt;
      end else if (w_pend_clr) begin
        r_pend    <= 1'b0;
      end
    end
  end

  assign o_npc         = i_rst_n ? w_npc : RESET_PC;
  assign o_imem_req    = (r_state == S_FETCH);
  assign o_imem_addr   = r_addr;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = (r_state == S_HOLD);
  assign o_align_err   = r_align_err;

endmodule
